// File: rtl/clock_pkg.sv
// clock_pkg: shared definitions for the clock set/run controller.
//   - state_e      : controller state, also the edit_sel output code
//   - HOUR_W/MINSEC_W : field widths of the hour and minute/second counters
//   - HOUR_MAX/MINSEC_MAX : last legal value of each field before wrap
//   - field_inc()  : wrap-around increment used when a field is set by hand
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2,
        ST_SET_S = 2'd3
    } state_e;

    localparam int unsigned HOUR_W   = 5;
    localparam int unsigned MINSEC_W = 6;

    localparam logic [MINSEC_W-1:0] HOUR_MAX   = 6'd23;
    localparam logic [MINSEC_W-1:0] MINSEC_MAX = 6'd59;

    // Anything at or above the field maximum (including corrupt values
    // from the counter) restarts the field at 0.
    function automatic logic [MINSEC_W-1:0] field_inc(
        input logic [MINSEC_W-1:0] val,
        input logic [MINSEC_W-1:0] max_val
    );
        logic [MINSEC_W-1:0] res;
        if (val >= max_val) begin
            res = 6'd0;
        end else begin
            res = val + 6'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running divider producing a one-cycle registered pulse.
//   clk   in  : system clock
//   rst   in  : synchronous active-high reset (counter 0, pulse 0)
//   clr   in  : synchronous hold-at-0; also suppresses the pulse
//   pulse out : high for exactly the cycle in which the counter is DIV-1
module tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic pulse
);

    localparam int unsigned    CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pulse_q;

    // Next count: hold at 0 while cleared, otherwise count 0..DIV-1 and wrap
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == LAST) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter and pulse registers; the pulse is computed from the next count
    // so it is aligned with the cycle in which the counter holds DIV-1
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= {CW{1'b0}};
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= !clr && (cnt_d == LAST);
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: run/set sequencer for the hour/minute/second counter chain.
//   clk, rst           : system clock, synchronous active-high reset
//   btn_mode, btn_inc  : debounced button levels (mode/advance, increment)
//   hour_in/min_in/sec_in : current counter values
//   tick               : 1 Hz count enable for the seconds counter (RUN only)
//   load, loaden_h/m/s : one-cycle load value and per-field load strobes
//   edit_sel           : state code (0 RUN, 1 hour, 2 minute, 3 second)
//   blink              : blank phase for the field being edited
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned BLINK_DIV = CLK_HZ / 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_mode,
    input  logic                btn_inc,
    input  logic [HOUR_W-1:0]   hour_in,
    input  logic [MINSEC_W-1:0] min_in,
    input  logic [MINSEC_W-1:0] sec_in,
    output logic                tick,
    output logic [MINSEC_W-1:0] load,
    output logic                loaden_h,
    output logic                loaden_m,
    output logic                loaden_s,
    output logic [1:0]          edit_sel,
    output logic                blink
);

    // Button sample and previous-sample registers; both reset to 1 so a
    // button held through reset is not seen as a fresh press.
    logic mode_s_q, mode_p_q;
    logic inc_s_q, inc_p_q;

    state_e              state_q, state_d;
    logic [MINSEC_W-1:0] load_q, load_d;
    logic                ldh_q, ldh_d;
    logic                ldm_q, ldm_d;
    logic                lds_q, lds_d;
    logic                blink_q;

    logic mode_press_s;
    logic inc_press_s;
    logic inc_accept_s;
    logic tick_clr_s;
    logic blink_clr_s;
    logic blink_pulse_s;
    logic tick_s;

    assign mode_press_s = mode_s_q && !mode_p_q;
    assign inc_press_s  = inc_s_q && !inc_p_q;

    // Next state and load strobes; a mode press takes priority and discards
    // a simultaneous increment press
    always_comb begin
        state_d      = state_q;
        load_d       = 6'd0;
        ldh_d        = 1'b0;
        ldm_d        = 1'b0;
        lds_d        = 1'b0;
        inc_accept_s = 1'b0;
        if (mode_press_s) begin
            case (state_q)
                ST_RUN:   state_d = ST_SET_H;
                ST_SET_H: state_d = ST_SET_M;
                ST_SET_M: state_d = ST_SET_S;
                ST_SET_S: state_d = ST_RUN;
                default:  state_d = ST_RUN;
            endcase
        end else if (inc_press_s) begin
            case (state_q)
                ST_SET_H: begin
                    inc_accept_s = 1'b1;
                    load_d       = field_inc({1'b0, hour_in}, HOUR_MAX);
                    ldh_d        = 1'b1;
                end
                ST_SET_M: begin
                    inc_accept_s = 1'b1;
                    load_d       = field_inc(min_in, MINSEC_MAX);
                    ldm_d        = 1'b1;
                end
                ST_SET_S: begin
                    inc_accept_s = 1'b1;
                    load_d       = field_inc(sec_in, MINSEC_MAX);
                    lds_d        = 1'b1;
                end
                default: begin
                    inc_accept_s = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // The prescaler is held while in, entering or leaving a SET state, so no
    // tick can slip out on the entry edge and RUN always restarts from 0.
    assign tick_clr_s  = (state_q != ST_RUN) || (state_d != ST_RUN);
    // Blink restarts from its visible phase on every state change and on
    // every accepted increment so the new value shows immediately.
    assign blink_clr_s = (state_d == ST_RUN) || (state_d != state_q) || inc_accept_s;

    tick_gen #(.DIV(CLK_HZ)) u_sec_tick (
        .clk   (clk),
        .rst   (rst),
        .clr   (tick_clr_s),
        .pulse (tick_s)
    );

    tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
        .clk   (clk),
        .rst   (rst),
        .clr   (blink_clr_s),
        .pulse (blink_pulse_s)
    );

    // Controller registers: button history, state, load strobes and blink
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_s_q <= 1'b1;
            mode_p_q <= 1'b1;
            inc_s_q  <= 1'b1;
            inc_p_q  <= 1'b1;
            state_q  <= ST_RUN;
            load_q   <= 6'd0;
            ldh_q    <= 1'b0;
            ldm_q    <= 1'b0;
            lds_q    <= 1'b0;
            blink_q  <= 1'b0;
        end else begin
            mode_s_q <= btn_mode;
            mode_p_q <= mode_s_q;
            inc_s_q  <= btn_inc;
            inc_p_q  <= inc_s_q;
            state_q  <= state_d;
            load_q   <= load_d;
            ldh_q    <= ldh_d;
            ldm_q    <= ldm_d;
            lds_q    <= lds_d;
            if (blink_clr_s) begin
                blink_q <= 1'b0;
            end else if (blink_pulse_s) begin
                blink_q <= ~blink_q;
            end else begin
                blink_q <= blink_q;
            end
        end
    end

    assign tick     = tick_s;
    assign load     = load_q;
    assign loaden_h = ldh_q;
    assign loaden_m = ldm_q;
    assign loaden_s = lds_q;
    assign edit_sel = state_q;
    assign blink    = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: scoreboard bench for clock_set_ctrl with CLK_HZ=10,
// BLINK_DIV=4. Stimulus pushes the expected output events (tick, load
// strobes, edit_sel or blink changes) with their cycle numbers; a monitor
// pops and compares whenever the DUT presents such an event.
module tb_clock_set_ctrl;

    typedef struct {
        int         cyc;
        logic       tk;
        logic       lh;
        logic       lm;
        logic       ls;
        logic [5:0] ld;
        logic [1:0] sel;
        logic       bl;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] hour_in;
    logic [5:0] min_in;
    logic [5:0] sec_in;
    logic       tick;
    logic [5:0] load;
    logic       loaden_h;
    logic       loaden_m;
    logic       loaden_s;
    logic [1:0] edit_sel;
    logic       blink;

    int  cyc     = 0;
    int  n_pass  = 0;
    int  n_checks = 0;
    bit  mon_en  = 1'b0;
    int  r0;
    ev_t exp_q[$];

    clock_set_ctrl #(.CLK_HZ(10), .BLINK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .hour_in  (hour_in),
        .min_in   (min_in),
        .sec_in   (sec_in),
        .tick     (tick),
        .load     (load),
        .loaden_h (loaden_h),
        .loaden_m (loaden_m),
        .loaden_s (loaden_s),
        .edit_sel (edit_sel),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Advance to 1 time unit after rising edge number c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_ev(input int c, input bit t, input bit h, input bit m,
                           input bit s, input int ld, input int sel, input bit bl);
        ev_t e;
        e.cyc = c;
        e.tk  = t;
        e.lh  = h;
        e.lm  = m;
        e.ls  = s;
        e.ld  = 6'(ld);
        e.sel = 2'(sel);
        e.bl  = bl;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d required=%0d", name, got, exp);
    endtask

    // Monitor: compares every output event against the head of the queue.
    initial begin : monitor
        ev_t        e;
        logic [1:0] prev_sel;
        logic       prev_bl;
        logic       is_ev;
        prev_sel = 2'd0;
        prev_bl  = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    $display("FAIL missed_event cyc=%0d got=no_event required tick=%0b lh=%0b lm=%0b ls=%0b load=%0d sel=%0d blink=%0b",
                             e.cyc, e.tk, e.lh, e.lm, e.ls, e.ld, e.sel, e.bl);
                end
                is_ev = (tick !== 1'b0) || (loaden_h !== 1'b0) || (loaden_m !== 1'b0) ||
                        (loaden_s !== 1'b0) || (load !== 6'd0) ||
                        (edit_sel !== prev_sel) || (blink !== prev_bl);
                if (is_ev) begin
                    n_checks++;
                    if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                        $display("FAIL unexpected_event cyc=%0d got tick=%0b lh=%0b lm=%0b ls=%0b load=%0d sel=%0d blink=%0b required=no_event",
                                 cyc, tick, loaden_h, loaden_m, loaden_s, load, edit_sel, blink);
                    end else begin
                        e = exp_q.pop_front();
                        if (tick === e.tk && loaden_h === e.lh && loaden_m === e.lm &&
                            loaden_s === e.ls && load === e.ld && edit_sel === e.sel &&
                            blink === e.bl) begin
                            n_pass++;
                        end else begin
                            $display("FAIL event cyc=%0d got tick=%0b lh=%0b lm=%0b ls=%0b load=%0d sel=%0d blink=%0b required tick=%0b lh=%0b lm=%0b ls=%0b load=%0d sel=%0d blink=%0b",
                                     cyc, tick, loaden_h, loaden_m, loaden_s, load, edit_sel, blink,
                                     e.tk, e.lh, e.lm, e.ls, e.ld, e.sel, e.bl);
                        end
                    end
                end
                prev_sel = edit_sel;
                prev_bl  = blink;
            end
        end
    end

    // Stimulus: directed scenarios with hand-computed event cycles.
    initial begin : stim
        rst      = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        hour_in  = 5'd5;
        min_in   = 6'd59;
        sec_in   = 6'd0;

        // Reset state
        goto(3);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_load", 32'(load), 32'd0);
        check("rst_ldh", 32'(loaden_h), 32'd0);
        check("rst_ldm", 32'(loaden_m), 32'd0);
        check("rst_lds", 32'(loaden_s), 32'd0);
        check("rst_sel", 32'(edit_sel), 32'd0);
        check("rst_blink", 32'(blink), 32'd0);
        r0 = cyc;
        rst = 1'b0;
        mon_en = 1'b1;

        // Run: ticks 9, 19, 29 cycles after release
        push_ev(r0 + 9, 1, 0, 0, 0, 0, 0, 0);
        push_ev(r0 + 19, 1, 0, 0, 0, 0, 0, 0);
        push_ev(r0 + 29, 1, 0, 0, 0, 0, 0, 0);

        // Four mode presses; first tick restarts after returning to RUN
        goto(r0 + 35);
        push_ev(r0 + 37, 0, 0, 0, 0, 0, 1, 0);
        push_ev(r0 + 40, 0, 0, 0, 0, 0, 2, 0);
        push_ev(r0 + 43, 0, 0, 0, 0, 0, 3, 0);
        push_ev(r0 + 46, 0, 0, 0, 0, 0, 0, 0);
        push_ev(r0 + 55, 1, 0, 0, 0, 0, 0, 0);
        btn_mode = 1'b1;
        goto(r0 + 36); btn_mode = 1'b0;
        goto(r0 + 38); btn_mode = 1'b1;
        goto(r0 + 39); btn_mode = 1'b0;
        goto(r0 + 41); btn_mode = 1'b1;
        goto(r0 + 42); btn_mode = 1'b0;
        goto(r0 + 44); btn_mode = 1'b1;
        goto(r0 + 45); btn_mode = 1'b0;

        // SET_H: hour 23 wraps to 0, hour 5 loads 6, then blink resumes
        goto(r0 + 56);
        push_ev(r0 + 58, 0, 0, 0, 0, 0, 1, 0);
        push_ev(r0 + 60, 0, 1, 0, 0, 0, 1, 0);
        push_ev(r0 + 63, 0, 1, 0, 0, 6, 1, 0);
        push_ev(r0 + 67, 0, 0, 0, 0, 0, 1, 1);
        push_ev(r0 + 70, 0, 0, 0, 0, 0, 2, 0);
        btn_mode = 1'b1;
        goto(r0 + 57); btn_mode = 1'b0;
        goto(r0 + 58); hour_in = 5'd23; btn_inc = 1'b1;
        goto(r0 + 59); btn_inc = 1'b0;
        goto(r0 + 61); hour_in = 5'd5; btn_inc = 1'b1;
        goto(r0 + 62); btn_inc = 1'b0;
        goto(r0 + 68); btn_mode = 1'b1;
        goto(r0 + 69); btn_mode = 1'b0;

        // SET_M: minute 59 with inc held 20 cycles gives one strobe; then
        // SET_S with mode and inc rising together returns to RUN, no strobe
        goto(r0 + 70);
        push_ev(r0 + 72, 0, 0, 1, 0, 0, 2, 0);
        push_ev(r0 + 76, 0, 0, 0, 0, 0, 2, 1);
        push_ev(r0 + 80, 0, 0, 0, 0, 0, 2, 0);
        push_ev(r0 + 84, 0, 0, 0, 0, 0, 2, 1);
        push_ev(r0 + 88, 0, 0, 0, 0, 0, 2, 0);
        push_ev(r0 + 92, 0, 0, 0, 0, 0, 2, 1);
        push_ev(r0 + 95, 0, 0, 0, 0, 0, 3, 0);
        push_ev(r0 + 98, 0, 0, 0, 0, 0, 0, 0);
        push_ev(r0 + 107, 1, 0, 0, 0, 0, 0, 0);
        btn_inc = 1'b1;
        goto(r0 + 90); btn_inc = 1'b0;
        goto(r0 + 93); btn_mode = 1'b1; sec_in = 6'd30;
        goto(r0 + 94); btn_mode = 1'b0;
        goto(r0 + 96); btn_mode = 1'b1; btn_inc = 1'b1;
        goto(r0 + 97); btn_mode = 1'b0; btn_inc = 1'b0;

        // Reset in SET_M while blink=1, with btn_mode held through reset
        goto(r0 + 108);
        push_ev(r0 + 110, 0, 0, 0, 0, 0, 1, 0);
        push_ev(r0 + 113, 0, 0, 0, 0, 0, 2, 0);
        push_ev(r0 + 117, 0, 0, 0, 0, 0, 2, 1);
        push_ev(r0 + 119, 0, 0, 0, 0, 0, 0, 0);
        btn_mode = 1'b1;
        goto(r0 + 109); btn_mode = 1'b0;
        goto(r0 + 111); btn_mode = 1'b1;
        goto(r0 + 112); btn_mode = 1'b0;
        goto(r0 + 118); btn_mode = 1'b1; rst = 1'b1;
        goto(r0 + 120);
        check("midrst_sel", 32'(edit_sel), 32'd0);
        check("midrst_blink", 32'(blink), 32'd0);
        check("midrst_ldm", 32'(loaden_m), 32'd0);
        check("midrst_load", 32'(load), 32'd0);
        goto(r0 + 121);
        rst = 1'b0;
        push_ev(r0 + 130, 1, 0, 0, 0, 0, 0, 0);
        push_ev(r0 + 140, 1, 0, 0, 0, 0, 0, 0);
        goto(r0 + 135); btn_mode = 1'b0;
        goto(r0 + 146);
        @(negedge clk);
        #1;

        // Every expected event must have been consumed
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL queue_drain got=%0d pending required=0 (first at cyc %0d)",
                     exp_q.size(), exp_q[0].cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Sequencing controller for the `countup` hour/minute/second counter chain of the Spartan-3 clock. It generates the 1 Hz count-enable tick in run mode. It also implements a button-driven set mode that steps through hours, minutes and seconds, issuing one-cycle `load`/`loaden` strobes with the incremented field value. It sits between the debounced board buttons and the three `countup` instances.

## Interface
- `CLK_HZ`, 50_000_000: clk cycles per 1 Hz tick.
- `BLINK_DIV`, CLK_HZ/2: clk cycles per half-period of the edit-field blink.
- Reset: one clock; reset is synchronous and active-high.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_mode` in 1: debounced level, mode/advance button.
- `btn_inc` in 1: debounced level, increment button.
- `hour_in` in 5: current hour from the hour `countup` (0–23).
- `min_in` in 6: current minute (0–59).
- `sec_in` in 6: current second (0–59).
- `tick` out 1: one-cycle count enable to the seconds `countup`.
- `load` out 6: value to load; for hours, bit 5 = 0.
- `loaden_h`, `loaden_m`, `loaden_s` out 1 each: one-cycle load strobes.
- `edit_sel` out 2: state code, 0 = RUN, 1 = hour, 2 = minute, 3 = second.
- `blink` out 1: display blank phase for the field being edited.

## Operation
- **States:** RUN (0), SET_H (1), SET_M (2), SET_S (3). `edit_sel` is the state register, output directly.
- **Press detection:** press = button high AND previous-sample low. Previous-sample registers reset to 1, so a button held through reset does not count as a press.
- **RUN:**
  - Prescaler counts 0..CLK_HZ-1 and wraps.
  - `tick`=1 for exactly the one cycle in which the prescaler = CLK_HZ-1.
  - `btn_inc` presses are ignored.
- **Mode press transitions:** RUN→SET_H→SET_M→SET_S→RUN.
- **While in any SET state:**
  - Prescaler is held at 0 and `tick`=0.
  - On SET_S→RUN the prescaler restarts from 0, so the first tick comes CLK_HZ cycles after the transition.
- **Increment press in SET_x:**
  - `load` = field+1, with wrap 23→0 for hours and 59→0 for minutes and seconds.
  - The matching `loaden_x` pulses for one cycle; the other strobes stay 0.
  - Out-of-range inputs (hour>23, min/sec>59) load 0.
- **Simultaneous mode and inc press:** mode wins and inc is discarded; no strobe.
- **`blink`:**
  - 0 in RUN.
  - On entry to any SET state, `blink` clears and the blink counter resets.
  - It then toggles every BLINK_DIV cycles.
  - An inc press forces `blink`=0 and restarts the blink counter, so the new value is visible.
- **Reset (any time, including mid-set):**
  - State RUN, prescaler 0, blink counter 0.
  - `tick`=0, `load`=0, all `loaden_*`=0, `blink`=0.

## Timing
- All outputs are registered.
- Button sampled high at edge k (previous sample low) → `loaden_x` and `load` valid during cycle k+1 → both clear at edge k+2 (`load` returns to 0).
- Mode press sampled at edge k → `edit_sel` changes at edge k+1.
- `tick` period is exactly CLK_HZ cycles in steady RUN, with no jitter.
- Held buttons produce a single press; a new press requires a release of at least one cycle.
- `rst` sampled high at edge k → all outputs at reset values from edge k; normal operation resumes at the first edge with `rst` low.

## Structure
- **Package `clock_pkg`:**
  - State encoding constants: ST_RUN, ST_SET_H, ST_SET_M, ST_SET_S.
  - HOUR_MAX=23, MINSEC_MAX=59.
  - Field widths 5/6.
- **Sub-module `tick_gen`:**
  - Parameterised divider with `clk`, `rst`, `clr` (sync hold-at-0) and `pulse` out.
  - Instantiated once for the 1 Hz tick (DIV=CLK_HZ) and once for the blink toggle (DIV=BLINK_DIV).
- The FSM, edge detect and wrap arithmetic live in the top module.

## Test plan
All scenarios use CLK_HZ=10 and BLINK_DIV=4.
- **Reset then run:** 35 cycles → `tick` high at cycles 9, 19, 29 after reset release; `edit_sel`=0, `blink`=0.
- **Mode press ×4:** `edit_sel` steps 1, 2, 3, 0, one cycle after each press. `tick` stays 0 while in SET states, and the first tick after returning to RUN comes 10 cycles later.
- **SET_H with hour_in=23, inc press:** next cycle `load`=0 and `loaden_h`=1 for exactly 1 cycle; with hour_in=5, `load`=6.
- **SET_M with min_in=59, inc held 20 cycles:** exactly one `loaden_m` pulse, `load`=0; `loaden_h`/`loaden_s` stay 0.
- **Mode and inc rise on the same edge in SET_S:** state goes to RUN and no `loaden_*` is asserted.
- **`rst` asserted in SET_M while `blink`=1:** the following cycle shows `edit_sel`=0, `blink`=0, all strobes 0. `btn_mode` held through reset produces no transition after release.
